// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed hex display counter.
//   - seg_bit_e : bit position of each segment on the segment bus (a = bit0 .. g = bit6)
//   - HEX_SEG   : hex digit -> 7-segment pattern, 1 = segment lit
//   - scan_state_e : scan FSM states
//   - cnt_width : bits needed to hold the values 0..n-1 (never less than 1)
package display_pkg;

  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam int SEG_W = int'(SEG_G) + 1;

  typedef logic [SEG_W-1:0] seg_t;

  // Index = nibble value; patterns are gfedcba with 1 = lit.
  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,  // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,  // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,  // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71   // C d E F
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-DIV prescaler with a single-cycle terminal tick.
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   en      : advance the prescaler; when low it holds its value
//   clr     : synchronous clear to 0, wins over en and suppresses tick
//   tick    : high during the cycle the prescaler holds DIV-1 (and en=1, clr=0)
module tick_gen
  import display_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("tick_gen: DIV must be at least 1");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && !clr && (cnt_q == LAST);

  // NOTE: every path assigns cnt_d from a default first, so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_counter.sv
// N-digit hexadecimal up/down counter driving a multiplexed 7-segment display.
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   en       : count enable (count prescaler holds when low)
//   up       : 1 = increment, 0 = decrement, sampled on the step cycle
//   load     : synchronous load strobe, wins over a coincident step
//   load_val : value loaded on load
//   led_port : registered segment drive, 1 = lit, bit0 = a
//   sel      : registered one-hot digit select, bit0 = rightmost digit
//   count    : registered counter value
//   wrap     : one-cycle pulse, coincident with the wrapped count
module display_scan_counter
  import display_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int DW        = 7,
  parameter int CLK_HZ    = 12000000,
  parameter int COUNT_HZ  = 1,
  parameter int SCAN_HZ   = 50,
  parameter int BLANK_CYC = 16,
  parameter int LZ_BLANK  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [DW-1:0]         led_port,
  output logic [DIGITS-1:0]     sel,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap
);

  localparam int CW      = 4 * DIGITS;
  localparam int CNT_DIV = CLK_HZ / COUNT_HZ;
  localparam int SLOT    = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int DIG_W   = cnt_width(DIGITS);
  localparam int BW      = cnt_width(BLANK_CYC);

  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(DIGITS - 1);
  localparam logic [BW-1:0]    BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("display_scan_counter: DIGITS must be 1..8");
  end
  if (CNT_DIV < 1) begin : g_bad_cnt_div
    $error("display_scan_counter: CLK_HZ/COUNT_HZ must be at least 1");
  end
  if (BLANK_CYC < 0 || SLOT <= BLANK_CYC) begin : g_bad_slot
    $error("display_scan_counter: need SLOT > BLANK_CYC >= 0");
  end

  // ---------------------------------------------------------------------------
  // Count path
  // ---------------------------------------------------------------------------
  logic          step;
  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;

  // load clears the prescaler so the next step is a full CNT_DIV after the load.
  tick_gen #(.DIV(CNT_DIV)) u_count_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clr     (load),
    .tick    (step)
  );

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (step) begin
      if (up) begin
        count_d = count_q + 1'b1;
        wrap_d  = &count_q;
      end else begin
        count_d = count_q - 1'b1;
        wrap_d  = ~|count_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

  // ---------------------------------------------------------------------------
  // Scan path
  // ---------------------------------------------------------------------------
  logic slot_end;

  // Slot timer runs regardless of en so the display never freezes.
  tick_gen #(.DIV(SLOT)) u_slot_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .clr     (1'b0),
    .tick    (slot_end)
  );

  scan_state_e      state_q, state_d;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic [BW-1:0]    blank_q, blank_d;
  logic             blank_done;

  // blank_q starts at 0 together with the slot timer, so it tracks the slot
  // position during BLANK.
  assign blank_done = (BLANK_CYC == 0) || (blank_q == BLANK_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_BLANK;
      digit_q <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    blank_d = blank_q;
    case (state_q)
      ST_BLANK: begin
        if (blank_done) begin
          state_d = ST_SHOW;
          blank_d = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (slot_end) begin
          digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
          state_d = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Per-digit nibbles and leading-zero mask. A digit is suppressed when it and
  // every digit to its left are zero; digit 0 is never suppressed.
  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] lz_mask;
  logic              upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib[i]     = count_q[4*i +: 4];
      upper_zero = upper_zero && (count_q[4*i +: 4] == 4'h0);
      lz_mask[i] = (LZ_BLANK != 0) && (i != 0) && upper_zero;
    end
  end

  // Output logic: sel and led_port come from one registered stage so they
  // always switch on the same edge.
  logic [DIGITS-1:0] sel_d, sel_q;
  logic [DW-1:0]     led_d, led_q;

  always_comb begin
    sel_d = '0;
    led_d = '0;
    if (state_q == ST_SHOW) begin
      sel_d[digit_q] = 1'b1;
      if (!lz_mask[digit_q]) begin
        led_d = DW'(HEX_SEG[nib[digit_q]]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q <= '0;
      led_q <= '0;
    end else begin
      sel_q <= sel_d;
      led_q <= led_d;
    end
  end

  assign sel      = sel_q;
  assign led_port = led_q;

endmodule

// File: tb/tb_display_scan_counter.sv
// Self-checking bench for display_scan_counter (2 digits, CNT_DIV=10, SLOT=2,
// BLANK_CYC=1). Two instances share all inputs: one plain, one with leading-zero
// suppression. Count changes are checked against a scoreboard of expected
// (cycle, value, wrap) entries; scan output is checked against queued patterns.
module tb_display_scan_counter;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;

  logic [6:0] led_m, led_l;
  logic [1:0] sel_m, sel_l;
  logic [7:0] count_m, count_l;
  logic       wrap_m, wrap_l;

  display_scan_counter #(
    .DIGITS(2), .DW(7), .CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(25),
    .BLANK_CYC(1), .LZ_BLANK(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .led_port(led_m), .sel(sel_m), .count(count_m),
    .wrap(wrap_m)
  );

  display_scan_counter #(
    .DIGITS(2), .DW(7), .CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(25),
    .BLANK_CYC(1), .LZ_BLANK(1)
  ) dut_lz (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .led_port(led_l), .sel(sel_l), .count(count_l),
    .wrap(wrap_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk  = 0;
  int fail = 0;

  int unsigned cyc = 0;
  logic        rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset_n;
  end

  typedef struct {
    int unsigned cyc;
    logic [7:0]  cnt;
    logic        wrap;
  } step_t;

  typedef struct {
    logic [1:0] sel;
    logic [6:0] led_main;
    logic [6:0] led_lz;
  } scan_t;

  step_t      exp_q[$];
  scan_t      scan_q[$];
  logic [7:0] model_cnt = 8'h00;

  // Count monitor: every change of count must match the head of exp_q.
  logic [7:0] prev_cnt = 8'h00;
  step_t      mon_e;
  always @(negedge clk) begin
    if (!rst_seen) begin
      prev_cnt = count_m;
    end else if (count_m !== prev_cnt) begin
      if (exp_q.size() == 0) begin
        chk++; fail++;
        $display("FAIL unexpected_count_change: got %h at cycle %0d, expected no change", count_m, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk++;
        if (count_m !== mon_e.cnt) begin
          fail++;
          $display("FAIL count_value: got %h expected %h (cycle %0d)", count_m, mon_e.cnt, cyc);
        end
        chk++;
        if (cyc !== mon_e.cyc) begin
          fail++;
          $display("FAIL count_timing: got cycle %0d expected cycle %0d (value %h)", cyc, mon_e.cyc, count_m);
        end
        chk++;
        if (wrap_m !== mon_e.wrap) begin
          fail++;
          $display("FAIL wrap_with_step: got %b expected %b (count %h)", wrap_m, mon_e.wrap, count_m);
        end
      end
      prev_cnt = count_m;
    end else begin
      chk++;
      if (wrap_m !== 1'b0) begin
        fail++;
        $display("FAIL wrap_idle: got %b expected 0 (cycle %0d)", wrap_m, cyc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic push_step(input int unsigned c, input logic [7:0] v, input logic w);
    step_t e;
    e.cyc = c; e.cnt = v; e.wrap = w;
    exp_q.push_back(e);
    model_cnt = v;
  endtask

  task automatic push_scan(input logic [1:0] s, input logic [6:0] lm, input logic [6:0] ll);
    scan_t e;
    e.sel = s; e.led_main = lm; e.led_lz = ll;
    scan_q.push_back(e);
  endtask

  // Called at a negedge; count takes val at the next posedge.
  task automatic do_load(input logic [7:0] val);
    int unsigned c0;
    c0 = cyc;
    if (val !== model_cnt) push_step(c0 + 1, val, 1'b0);
    load     = 1'b1;
    load_val = val;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_until_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk++;
    if (exp_q.size() != 0) begin
      fail++;
      $display("FAIL step_timeout: got %0d pending steps expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_sel01(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sel_m === 2'b01) break;
      @(negedge clk);
    end
    chk++;
    if (sel_m !== 2'b01) begin
      fail++;
      $display("FAIL scan_sync_timeout: got sel %b expected 01", sel_m);
    end
  endtask

  task automatic run_scan_checks(input string tag);
    scan_t e;
    while (scan_q.size() != 0) begin
      e = scan_q.pop_front();
      chk++;
      if (sel_m !== e.sel) begin
        fail++;
        $display("FAIL %s_sel: got %b expected %b", tag, sel_m, e.sel);
      end
      chk++;
      if (sel_l !== e.sel) begin
        fail++;
        $display("FAIL %s_sel_lz: got %b expected %b", tag, sel_l, e.sel);
      end
      chk++;
      if (led_m !== e.led_main) begin
        fail++;
        $display("FAIL %s_led: got %h expected %h (sel %b)", tag, led_m, e.led_main, e.sel);
      end
      chk++;
      if (led_l !== e.led_lz) begin
        fail++;
        $display("FAIL %s_led_lz: got %h expected %h (sel %b)", tag, led_l, e.led_lz, e.sel);
      end
      chk++;
      if (!$onehot0(sel_m)) begin
        fail++;
        $display("FAIL %s_onehot: got %b expected at most one bit set", tag, sel_m);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk++;
    if (count_m !== 8'h00) begin fail++; $display("FAIL %s_count: got %h expected 00", tag, count_m); end
    chk++;
    if (wrap_m !== 1'b0) begin fail++; $display("FAIL %s_wrap: got %b expected 0", tag, wrap_m); end
    chk++;
    if (sel_m !== 2'b00) begin fail++; $display("FAIL %s_sel: got %b expected 00", tag, sel_m); end
    chk++;
    if (led_m !== 7'h00) begin fail++; $display("FAIL %s_led: got %h expected 00", tag, led_m); end
    chk++;
    if (count_l !== 8'h00) begin fail++; $display("FAIL %s_count_lz: got %h expected 00", tag, count_l); end
    chk++;
    if (sel_l !== 2'b00 || led_l !== 7'h00) begin
      fail++; $display("FAIL %s_lz_outputs: got sel %b led %h expected 00/00", tag, sel_l, led_l);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
  endtask

  task automatic test_count_up();
    int unsigned c0;
    c0 = cyc;
    reset_n = 1'b1;
    en      = 1'b1;
    up      = 1'b1;
    push_step(c0 + 10, 8'h01, 1'b0);
    push_step(c0 + 20, 8'h02, 1'b0);
    wait_drain(30);
  endtask

  task automatic test_wrap_up();
    int unsigned c0;
    up = 1'b1;
    c0 = cyc;
    do_load(8'hFE);
    push_step(c0 + 11, 8'hFF, 1'b0);
    push_step(c0 + 21, 8'h00, 1'b1);
    wait_drain(30);
  endtask

  task automatic test_wrap_down();
    int unsigned c0;
    up = 1'b0;
    c0 = cyc;
    do_load(8'h00);
    push_step(c0 + 11, 8'hFF, 1'b1);
    wait_drain(30);
  endtask

  task automatic test_load_vs_step();
    int unsigned c0;
    up = 1'b1;
    c0 = cyc;
    do_load(8'h10);
    // Prescaler sits at its terminal value during cycle c0+10.
    wait_until_cyc(c0 + 10);
    do_load(8'h3C);
    push_step(c0 + 21, 8'h3D, 1'b0);
    wait_drain(30);
  endtask

  task automatic test_hold();
    en = 1'b0;
    do_load(8'h3C);
    repeat (30) @(negedge clk);
    chk++;
    if (count_m !== 8'h3C) begin
      fail++;
      $display("FAIL hold_count: got %h expected 3c", count_m);
    end
    chk++;
    if (exp_q.size() != 0) begin
      fail++;
      $display("FAIL hold_pending: got %0d pending steps expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_scan();
    for (int r = 0; r < 2; r++) begin
      push_scan(2'b01, 7'h39, 7'h39);
      push_scan(2'b00, 7'h00, 7'h00);
      push_scan(2'b10, 7'h4F, 7'h4F);
      push_scan(2'b00, 7'h00, 7'h00);
    end
    wait_sel01(20);
    run_scan_checks("scan");
  endtask

  task automatic test_lz();
    do_load(8'h05);
    repeat (2) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      push_scan(2'b01, 7'h6D, 7'h6D);
      push_scan(2'b00, 7'h00, 7'h00);
      push_scan(2'b10, 7'h3F, 7'h00);
      push_scan(2'b00, 7'h00, 7'h00);
    end
    wait_sel01(20);
    run_scan_checks("lz");
  endtask

  task automatic test_reset_mid_show();
    for (int i = 0; i < 10; i++) begin
      if (sel_m !== 2'b00) break;
      @(negedge clk);
    end
    chk++;
    if (sel_m === 2'b00) begin
      fail++;
      $display("FAIL show_sync_timeout: got sel %b expected nonzero", sel_m);
    end
    reset_n  = 1'b0;
    load     = 1'b1;
    load_val = 8'hAA;
    @(negedge clk);
    check_all_zero("mid_reset");
    model_cnt = 8'h00;
    reset_n   = 1'b1;
    load      = 1'b0;
    @(negedge clk);
    chk++;
    if (sel_m !== 2'b00 || led_m !== 7'h00) begin
      fail++;
      $display("FAIL first_blank: got sel %b led %h expected 00/00", sel_m, led_m);
    end
    @(negedge clk);
    chk++;
    if (sel_m !== 2'b01 || led_m !== 7'h3F) begin
      fail++;
      $display("FAIL first_show: got sel %b led %h expected 01/3f", sel_m, led_m);
    end
    chk++;
    if (count_m !== 8'h00) begin
      fail++;
      $display("FAIL reset_over_load: got %h expected 00", count_m);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_load_vs_step();
    test_hold();
    test_scan();
    test_lz();
    test_reset_mid_show();
    $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expired expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/display_scan_counter.md
# display_scan_counter

Parametrised N-digit hexadecimal counter with a multiplexed 7-segment display driver. It generalises the 2-digit 00–FF demonstrator:
- digit count, count rate and scan rate are parameters;
- it adds up/down counting, synchronous load, a wrap pulse, inter-digit blanking (anti-ghosting) and optional leading-zero suppression.

It sits directly at the board pins: segment bus plus one-hot digit-select lines.

## Interface
- `DIGITS`, 2: number of multiplexed digits, 1..8; counter width is 4·DIGITS.
- `DW`, 7: segment bus width; bit0=a … bit6=g.
- `CLK_HZ`, 12000000: input clock frequency.
- `COUNT_HZ`, 1: count step rate.
- `SCAN_HZ`, 50: full refresh rate (all digits).
- `BLANK_CYC`, 16: cycles at the start of every digit slot with all selects off.
- `LZ_BLANK`, 0: 1 = suppress leading zeros (the least-significant digit is always shown).

Ports:
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `en` in 1: counting enable; when low, the count prescaler holds.
- `up` in 1: 1 = increment, 0 = decrement.
- `load` in 1: synchronous load strobe.
- `load_val` in 4·DIGITS: value loaded on `load`.
- `led_port` out DW: segment drive, 1 = segment lit, registered.
- `sel` out DIGITS: one-hot digit select, 1 = digit on, bit0 = least-significant (rightmost) digit, registered.
- `count` out 4·DIGITS: current count value, registered.
- `wrap` out 1: one-cycle pulse on counter wrap.

## Operation
Derived constants, integer-truncated:
- `CNT_DIV = CLK_HZ/COUNT_HZ`
- `SLOT = CLK_HZ/(SCAN_HZ·DIGITS)`
- `SLOT > BLANK_CYC ≥ 0` is required; elaboration fails otherwise.

Count path:
- The prescaler counts 0..CNT_DIV-1 while `en` = 1. A step occurs on the cycle it equals CNT_DIV-1; the prescaler then returns to 0.
- Step arithmetic is modulo 2^(4·DIGITS).
  - Up: max→0 asserts `wrap`.
  - Down: 0→max asserts `wrap`.
- `load` has priority over a coincident step:
  - `count` ← `load_val` and the prescaler is cleared;
  - no `wrap` is produced and no step occurs that cycle.
- `en` = 0: prescaler and `count` hold. `load` still works.
- `up` is sampled on the step cycle only.

Scan path (independent of `en`), FSM states:
- BLANK: `sel` = 0 and `led_port` = 0 for BLANK_CYC cycles. Move to SHOW when the slot counter reaches BLANK_CYC-1. With BLANK_CYC = 0, SHOW is entered directly.
- SHOW: `sel` = one-hot(digit index), `led_port` = decode(nibble[digit index]).
  - At slot counter = SLOT-1: digit index advances (DIGITS-1 wraps to 0) and the FSM returns to BLANK.
- Decode is standard hex 0–F (A,b,C,d,E,F shapes).
- `LZ_BLANK` = 1: a digit above bit0 whose nibble and all higher nibbles are 0 drives `led_port` = 0. `sel` still asserts for that digit.
- `count` changing mid-slot updates `led_port` on the next cycle; the slot timing is unaffected.

## Timing
- Reset values:
  - `count` = 0, `wrap` = 0, `sel` = 0, `led_port` = 0;
  - FSM = BLANK, digit index = 0, both prescalers = 0.
- Reset asserted mid-operation reaches all outputs at the next rising edge. It overrides `load`.
- Latencies:
  - `load` at edge k gives `count` = `load_val` after edge k.
  - Step/`wrap` appears one cycle after the prescaler terminal value is registered. `wrap` is coincident with the wrapped `count`.
  - `led_port`/`sel` lag the internal digit index by one register stage. They always change together, never in separate cycles.
- First SHOW after reset begins at cycle BLANK_CYC+1, digit 0.

## Structure
- Shared package `display_pkg`:
  - hex→7-segment constant table (16×7);
  - segment bit-order constants;
  - `clog2`-style width helper.
- Sub-module `tick_gen` (params DIV; ports `clk`, `reset_n`, `en`, `clr`, `tick`), instanced twice:
  - count prescaler (`en` = `en`, `clr` = `load`);
  - scan slot timer (`en` = 1).
- Scan FSM, digit mux and decode live in the top module.

## Test plan
Parameters: CLK_HZ=100, COUNT_HZ=10, SCAN_HZ=25, DIGITS=2, BLANK_CYC=1 → CNT_DIV=10, SLOT=2.
- Reset released, `en`=1, `up`=1 → `count` = 01 after 10 cycles, 02 after 20.
- `load` `load_val`=FE, then count up → FF, then 00 with `wrap` high for exactly 1 cycle.
- `load` 00, `up`=0 → next step gives FF, `wrap`=1.
- `load` and the step terminal in the same cycle, `load_val`=0x3C → `count`=3C, `wrap`=0, and the next step is 10 cycles later.
- `count`=0x3C → repeating 4-cycle pattern:
  - `sel` = 00 during BLANK;
  - `sel` = 01 with `led_port` = 0x39 ('C');
  - `sel` = 00 during BLANK;
  - `sel` = 10 with `led_port` = 0x4F ('3').
  - Check one-hot `sel` and that `sel` and `led_port` change together.
- `LZ_BLANK`=1, `count`=0x05 → digit 1 slot `led_port` = 0 and digit 0 shows 0x6D. `reset_n` low mid-SHOW → all outputs 0 at the next edge.
